// File: rtl/mcntrl_arb_pkg.sv
// Shared definitions for the memory-controller sequencer arbiter.
package mcntrl_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_GRANT    = 2'd1,
      ARB_WAIT_SET = 2'd2
   } arb_state_e;

   localparam int ARB_SET_TIMEOUT_DFLT = 15;

endpackage

// File: rtl/mcntrl_seq_arbiter_if.sv
// Channel/sequencer-side bus of the sequencer arbiter.
interface mcntrl_seq_arbiter_if #(
   parameter int NUM_CHN   = 4,
   parameter int CHN_BITS  = 2,
   parameter int PEND_BITS = 4
);
   logic [NUM_CHN-1:0]   chn_en;
   logic [NUM_CHN-1:0]   want_rq;
   logic [NUM_CHN-1:0]   need_rq;
   logic [NUM_CHN-1:0]   channel_pgm_en;
   logic                 seq_set;
   logic                 seq_done;
   logic [CHN_BITS-1:0]  grant_chn;
   logic [PEND_BITS-1:0] pending;
   logic                 busy;
   logic                 err;
   logic                 clear_err;

   // Arbiter side
   modport slave (
      input  chn_en, want_rq, need_rq, seq_set, seq_done, clear_err,
      output channel_pgm_en, grant_chn, pending, busy, err
   );

   // Channels, sequencer and control side
   modport master (
      output chn_en, want_rq, need_rq, seq_set, seq_done, clear_err,
      input  channel_pgm_en, grant_chn, pending, busy, err
   );
endinterface

// File: rtl/mcntrl_rr_pick.sv
// Rotating priority encoder: first set bit of req above ptr, wrapping.
module mcntrl_rr_pick #(
   parameter int NUM_CHN  = 4,
   parameter int CHN_BITS = 2
) (
   input  logic [NUM_CHN-1:0]  req,
   input  logic [CHN_BITS-1:0] ptr,
   output logic                any,
   output logic [CHN_BITS-1:0] idx
);
   logic [CHN_BITS-1:0] c;

   // Walk from farthest to nearest so the nearest hit is written last.
   always_comb begin
      any = 1'b0;
      idx = '0;
      c   = '0;
      for (int k = NUM_CHN; k >= 1; k--) begin
         c = CHN_BITS'((int'(ptr) + k) % NUM_CHN);
         if (req[c]) begin
            any = 1'b1;
            idx = c;
         end
      end
   end
endmodule

// File: rtl/mcntrl_seq_arbiter.sv
// Grants the shared DDR3 sequencer to one channel at a time and tracks
// sequences programmed but not yet completed.
module mcntrl_seq_arbiter
   import mcntrl_arb_pkg::*;
#(
   parameter int NUM_CHN     = 4,
   parameter int CHN_BITS    = 2,
   parameter int MAX_PENDING = 2,
   parameter int PEND_BITS   = 4,
   parameter int SET_TIMEOUT = ARB_SET_TIMEOUT_DFLT
) (
   input  logic mclk,
   input  logic rst_n,
   mcntrl_seq_arbiter_if.slave arb
);
   arb_state_e           state_q;
   logic [NUM_CHN-1:0]   pgm_en_q;
   logic [CHN_BITS-1:0]  grant_q, rr_q;
   logic [PEND_BITS-1:0] pend_q, pend_d;
   logic [7:0]           tmo_q;
   logic                 err_q, err_d;

   logic [NUM_CHN-1:0]   urg, norm;
   logic                 u_any, n_any;
   logic [CHN_BITS-1:0]  u_idx, n_idx, win;
   logic                 cand_any, set_ok, set_bad, underflow, timeout;

   assign urg  = arb.want_rq & arb.need_rq & arb.chn_en;
   assign norm = arb.want_rq & arb.chn_en;

   mcntrl_rr_pick #(.NUM_CHN(NUM_CHN), .CHN_BITS(CHN_BITS)) u_pick_urg (
      .req(urg), .ptr(rr_q), .any(u_any), .idx(u_idx));
   mcntrl_rr_pick #(.NUM_CHN(NUM_CHN), .CHN_BITS(CHN_BITS)) u_pick_norm (
      .req(norm), .ptr(rr_q), .any(n_any), .idx(n_idx));

   // Urgent requests mask opportunistic ones entirely.
   assign cand_any = u_any | n_any;
   assign win      = u_any ? u_idx : n_idx;

   assign set_ok    = arb.seq_set && (state_q == ARB_WAIT_SET);
   assign set_bad   = arb.seq_set && (state_q != ARB_WAIT_SET);
   assign underflow = arb.seq_done && !set_ok && (pend_q == '0);
   assign timeout   = (state_q == ARB_WAIT_SET) && !arb.seq_set && (tmo_q == '0);

   always_comb begin
      pend_d = pend_q;
      if (set_ok && !arb.seq_done && (pend_q != '1))
         pend_d = pend_q + 1'b1;
      else if (arb.seq_done && !set_ok && (pend_q != '0))
         pend_d = pend_q - 1'b1;
      err_d = err_q;
      if (set_bad || underflow || timeout)
         err_d = 1'b1;
      else if (arb.clear_err)
         err_d = 1'b0;
   end

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ARB_IDLE;
         pgm_en_q <= '0;
         grant_q  <= '0;
         rr_q     <= CHN_BITS'(NUM_CHN - 1);
         pend_q   <= '0;
         tmo_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         pgm_en_q <= '0;
         pend_q   <= pend_d;
         err_q    <= err_d;
         case (state_q)
            ARB_IDLE:
               if (cand_any && (pend_q < PEND_BITS'(MAX_PENDING))) begin
                  state_q  <= ARB_GRANT;
                  pgm_en_q <= NUM_CHN'(1) << win;
                  grant_q  <= win;
                  rr_q     <= win;
               end
            ARB_GRANT: begin
               state_q <= ARB_WAIT_SET;
               tmo_q   <= 8'(SET_TIMEOUT);
            end
            ARB_WAIT_SET:
               if (arb.seq_set || (tmo_q == '0))
                  state_q <= ARB_IDLE;
               else
                  tmo_q <= tmo_q - 1'b1;
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign arb.channel_pgm_en = pgm_en_q;
   assign arb.grant_chn      = grant_q;
   assign arb.pending        = pend_q;
   assign arb.err            = err_q;
   assign arb.busy           = (state_q != ARB_IDLE) || (pend_q != '0);
endmodule

// File: tb/tb_mcntrl_seq_arbiter.sv
// Directed bench for mcntrl_seq_arbiter: grant order, pending gate,
// timeout, error rules and asynchronous reset.
module tb_mcntrl_seq_arbiter;
   logic mclk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   mcntrl_seq_arbiter_if #(.NUM_CHN(4), .CHN_BITS(2), .PEND_BITS(4)) bus ();

   mcntrl_seq_arbiter #(
      .NUM_CHN(4), .CHN_BITS(2), .MAX_PENDING(2), .PEND_BITS(4), .SET_TIMEOUT(15)
   ) dut (
      .mclk(mclk), .rst_n(rst_n), .arb(bus)
   );

   always #5 mclk = ~mclk;

   initial begin
      #2000000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge mclk);
   endtask

   // Wait (bounded) for a grant pulse and check its width and channel.
   task automatic expect_grant(input string tag, input int exp);
      int n = 0;
      while (bus.channel_pgm_en == '0 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_seen"}, 32'(bus.channel_pgm_en != '0), 32'd1);
      chk({tag, "_onehot"}, 32'($countones(bus.channel_pgm_en)), 32'd1);
      chk({tag, "_pgm_en"}, 32'(bus.channel_pgm_en), 32'(1 << exp));
      chk({tag, "_grant_chn"}, 32'(bus.grant_chn), 32'(exp));
   endtask

   // Entered in the grant cycle; seq_set two cycles after the pgm_en rise.
   task automatic serve(input logic do_done);
      tick();
      bus.seq_set = 1'b1;
      tick();
      bus.seq_set  = 1'b0;
      bus.seq_done = do_done;
      tick();
      bus.seq_done = 1'b0;
   endtask

   initial begin
      bus.chn_en = '0; bus.want_rq = '0; bus.need_rq = '0;
      bus.seq_set = 1'b0; bus.seq_done = 1'b0; bus.clear_err = 1'b0;
      tick();
      chk("rst_pgm_en", 32'(bus.channel_pgm_en), 32'd0);
      chk("rst_grant_chn", 32'(bus.grant_chn), 32'd0);
      chk("rst_pending", 32'(bus.pending), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      tick();

      // Two opportunistic requesters alternate, channel 0 first.
      bus.chn_en = 4'hf; bus.want_rq = 4'b0101;
      expect_grant("alt0", 0); serve(1'b1);
      expect_grant("alt1", 2); serve(1'b1);
      expect_grant("alt2", 0); serve(1'b1);
      expect_grant("alt3", 2); bus.want_rq = '0; serve(1'b1);
      tick();
      chk("alt_pending", 32'(bus.pending), 32'd0);
      chk("alt_busy", 32'(bus.busy), 32'd0);

      // Urgent channel 3 first, then plain round-robin from it.
      bus.want_rq = 4'b1111; bus.need_rq = 4'b1000;
      expect_grant("urg", 3); bus.need_rq = '0; serve(1'b1);
      expect_grant("rr0", 0); serve(1'b1);
      expect_grant("rr1", 1); serve(1'b1);
      expect_grant("rr2", 2); bus.want_rq = '0; serve(1'b1);
      tick();

      // Pending gate: two grants without seq_done, then blocked.
      bus.want_rq = 4'b1111;
      expect_grant("pg0", 3); serve(1'b0);
      expect_grant("pg1", 0); serve(1'b0);
      begin
         int extra = 0;
         for (int i = 0; i < 20; i++) begin
            if (bus.channel_pgm_en != '0) extra++;
            tick();
         end
         chk("pg_blocked", 32'(extra), 32'd0);
      end
      chk("pg_pending2", 32'(bus.pending), 32'd2);
      chk("pg_busy", 32'(bus.busy), 32'd1);
      bus.seq_done = 1'b1; tick(); bus.seq_done = 1'b0;
      chk("pg_pending1", 32'(bus.pending), 32'd1);
      expect_grant("pg2", 1); bus.want_rq = '0; serve(1'b0);
      chk("pg_pending_back2", 32'(bus.pending), 32'd2);
      bus.seq_done = 1'b1; tick(); tick(); bus.seq_done = 1'b0;
      chk("pg_drain", 32'(bus.pending), 32'd0);
      chk("pg_err", 32'(bus.err), 32'd0);

      // seq_set timeout: err rises at the end of the 16th WAIT_SET cycle.
      bus.want_rq = 4'b0001;
      expect_grant("tmo", 0); bus.want_rq = '0;
      for (int i = 0; i < 16; i++) tick();
      chk("tmo_err_early", 32'(bus.err), 32'd0);
      chk("tmo_busy_wait", 32'(bus.busy), 32'd1);
      tick();
      chk("tmo_err", 32'(bus.err), 32'd1);
      chk("tmo_idle", 32'(bus.busy), 32'd0);
      chk("tmo_pending", 32'(bus.pending), 32'd0);
      bus.clear_err = 1'b1; tick(); bus.clear_err = 1'b0;
      chk("clr_err", 32'(bus.err), 32'd0);

      // Stray seq_set in IDLE together with clear_err: error wins, not counted.
      bus.seq_set = 1'b1; bus.clear_err = 1'b1; tick();
      bus.seq_set = 1'b0; bus.clear_err = 1'b0;
      chk("stray_set_err", 32'(bus.err), 32'd1);
      chk("stray_set_pending", 32'(bus.pending), 32'd0);
      bus.clear_err = 1'b1; tick(); bus.clear_err = 1'b0;

      // Underflow, then simultaneous set/done at pending=1.
      bus.seq_done = 1'b1; tick(); bus.seq_done = 1'b0;
      chk("uflow_pending", 32'(bus.pending), 32'd0);
      chk("uflow_err", 32'(bus.err), 32'd1);
      bus.clear_err = 1'b1; tick(); bus.clear_err = 1'b0;
      bus.want_rq = 4'b0001;
      expect_grant("sd0", 0); bus.want_rq = '0; serve(1'b0);
      chk("sd_pending1", 32'(bus.pending), 32'd1);
      bus.want_rq = 4'b0001;
      expect_grant("sd1", 0); bus.want_rq = '0;
      tick();
      bus.seq_set = 1'b1; bus.seq_done = 1'b1; tick();
      bus.seq_set = 1'b0; bus.seq_done = 1'b0;
      chk("sd_pending_same", 32'(bus.pending), 32'd1);
      chk("sd_err", 32'(bus.err), 32'd0);
      bus.seq_done = 1'b1; tick(); bus.seq_done = 1'b0;

      // Disabled channel is never granted.
      bus.chn_en = 4'b1110; bus.want_rq = 4'b0001;
      begin
         int seen = 0;
         for (int i = 0; i < 50; i++) begin
            if (bus.channel_pgm_en != '0) seen++;
            tick();
         end
         chk("dis_no_grant", 32'(seen), 32'd0);
      end
      chk("dis_busy", 32'(bus.busy), 32'd0);

      // Asynchronous reset while waiting for seq_set, with state to clear.
      bus.chn_en = 4'hf; bus.want_rq = 4'b0010;
      expect_grant("pre_rst0", 1); bus.want_rq = '0; serve(1'b0);
      bus.seq_set = 1'b1; tick(); bus.seq_set = 1'b0;
      bus.want_rq = 4'b0100;
      expect_grant("pre_rst1", 2); bus.want_rq = '0;
      tick();
      chk("pre_rst_pending", 32'(bus.pending), 32'd1);
      chk("pre_rst_err", 32'(bus.err), 32'd1);
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_pgm_en", 32'(bus.channel_pgm_en), 32'd0);
      chk("arst_grant_chn", 32'(bus.grant_chn), 32'd0);
      chk("arst_pending", 32'(bus.pending), 32'd0);
      chk("arst_err", 32'(bus.err), 32'd0);
      chk("arst_busy", 32'(bus.busy), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      bus.want_rq = 4'b1111;
      expect_grant("post_rst", 0); bus.want_rq = '0; serve(1'b1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mcntrl_seq_arbiter.md
Name: mcntrl_seq_arbiter

Overview:
- Shares the single DDR3 command sequencer between NUM_CHN memory channels (PS PIO, tiled and scanline channels).
- Each channel raises want_rq (opportunistic) or want_rq+need_rq (urgent).
- The arbiter grants one channel at a time with a one-cycle channel_pgm_en pulse, waits for that channel's seq_set, and tracks outstanding sequences until seq_done.
- It sits between the channel controllers and the sequencer inside the memory controller top.

Parameters:
- NUM_CHN, 4, number of requesting channels (2..16).
- CHN_BITS, 2, width of the channel index; must satisfy 2**CHN_BITS >= NUM_CHN.
- MAX_PENDING, 2, maximum sequences programmed but not yet done (1..15).
- PEND_BITS, 4, width of the pending counter.
- SET_TIMEOUT, 15, cycles to wait for seq_set after a grant before aborting (1..255).

Ports:
- mclk  in  1  system memory clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- chn_en  in  NUM_CHN  per-channel enable mask; a disabled channel is never granted.
- want_rq  in  NUM_CHN  per-channel request.
- need_rq  in  NUM_CHN  per-channel urgent request, qualified by want_rq.
- channel_pgm_en  out  NUM_CHN  one-hot grant pulse, one cycle wide.
- seq_set  in  1  OR of all channels' seq_set; the granted channel has written its sequence address.
- seq_done  in  1  sequencer finished one sequence.
- grant_chn  out  CHN_BITS  index of the last granted channel; held until the next grant.
- pending  out  PEND_BITS  count of outstanding sequences.
- busy  out  1  state != IDLE or pending != 0.
- err  out  1  sticky: seq_set timeout, seq_done underflow, or seq_set outside WAIT_SET.
- clear_err  in  1  synchronous clear of err.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - channel_pgm_en=0, grant_chn=0, pending=0, err=0.
  - Round-robin pointer rr=NUM_CHN-1, so channel 0 wins first.
- Eligibility:
  - urg = want_rq & need_rq & chn_en.
  - norm = want_rq & chn_en.
  - Candidate set = urg if urg != 0, else norm.
  - Winner = first set bit searching from rr+1 upward, wrapping modulo NUM_CHN.
- FSM states: IDLE, GRANT, WAIT_SET.
- IDLE:
  - Goes to GRANT when the candidate set != 0 and pending < MAX_PENDING.
  - On that edge it registers the winner: channel_pgm_en[w]=1, grant_chn=w, rr=w.
  - Latency: request sampled high at edge n gives channel_pgm_en high during cycle n+1.
- GRANT:
  - One cycle only.
  - channel_pgm_en returns to 0.
  - Next state is WAIT_SET and the timeout counter loads SET_TIMEOUT.
- WAIT_SET:
  - On seq_set: pending increments, state goes to IDLE.
  - The earliest next pgm_en is 2 cycles after seq_set.
  - Timeout counter decrements each cycle. At 0 without seq_set: err=1, state goes to IDLE, pending unchanged.
- Pending counter:
  - seq_set in WAIT_SET without seq_done: +1.
  - seq_done without a counted seq_set: -1.
  - Both in the same cycle: unchanged.
  - seq_done at pending=0: stays 0 and sets err.
  - Saturates at 2**PEND_BITS-1; the MAX_PENDING gate keeps it from getting there.
- Event rules:
  - seq_set outside WAIT_SET sets err and is not counted.
  - Requests that drop in GRANT or WAIT_SET do not abort the grant.
  - chn_en falling for the granted channel after its grant does not abort.
- clear_err and a new error event in the same cycle: error wins, err=1.
- Reset mid-operation aborts at once. The channels rely on their own reset to drop their requests.

Decomposition:
- Shared package mcntrl_arb_pkg:
  - State encoding constants ARB_IDLE=2'd0, ARB_GRANT=2'd1, ARB_WAIT_SET=2'd2.
  - Default timeout constant.
- One sub-module, mcntrl_rr_pick: combinational rotating priority encoder.
  - Inputs: req[NUM_CHN], ptr[CHN_BITS].
  - Outputs: any, idx[CHN_BITS].
  - Instantiated twice, once for urg and once for norm.

Test Plan:
- Reset, then want_rq=4'b0101 held, chn_en=4'hf; seq_set 2 cycles after each pgm_en; seq_done right after seq_set -> grants alternate ch0, ch2, ch0, ch2, and channel_pgm_en is never 2 bits wide.
- want_rq=4'b1111, need_rq=4'b1000 -> first grant ch3. Then need_rq=0 -> next grants ch0, ch1, ch2 in order.
- MAX_PENDING=2, all channels requesting, seq_set returned, no seq_done -> exactly 2 grants and pending=2. One seq_done pulse -> third grant, pending back to 2.
- Grant with no seq_set, SET_TIMEOUT=15 -> err=1 on the 16th cycle after GRANT and state IDLE. clear_err pulse -> err=0.
- seq_done at pending=0 -> pending stays 0, err=1. seq_set and seq_done in the same cycle at pending=1 -> pending stays 1.
- chn_en=4'b1110 with want_rq=4'b0001 -> no grant for 50 cycles and busy=0. rst_n pulsed low while in WAIT_SET -> all outputs 0 within the same cycle.
